// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM states and alignment helper for the load/store unit
package lsu_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    return (size == SIZE_HALF && lane[0]) || (size[1] && lane != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane extract/extend for loads or lane merge for sub-word stores
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic        merge,
  input  logic [31:0] wdata,
  output logic [31:0] data_out
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] ext;
  logic [31:0] merged;
  // merge=0 returns the extended load value, merge=1 the word with the new lane(s) inserted
  always_comb begin
    b = word_in[8*lane +: 8];
    h = lane[1] ? word_in[31:16] : word_in[15:0];
    ext = size == SIZE_BYTE ? {{24{b[7] & ~is_unsigned}}, b} :
          size == SIZE_HALF ? {{16{h[15] & ~is_unsigned}}, h} : word_in;
    merged = word_in;
    if (size == SIZE_BYTE) merged[8*lane +: 8] = wdata[7:0];
    else if (size == SIZE_HALF) merged[16*lane[1] +: 16] = wdata[15:0];
    else merged = wdata;
    data_out = merge ? merged : ext;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-request LSU driving a word-addressed data memory with sub-word RMW
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Req_Valid,
  output logic                  Req_Ready,
  input  logic                  Req_Write,
  input  logic [1:0]            Req_Size,
  input  logic                  Req_Unsigned,
  input  logic [ADDR_WIDTH+1:0] Req_Addr,
  input  logic [DATA_WIDTH-1:0] Req_Wdata,
  output logic                  Resp_Valid,
  output logic                  Resp_Error,
  output logic [DATA_WIDTH-1:0] Resp_Rdata,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data,
  output logic                  Mem_Write,
  output logic                  Mem_Read,
  input  logic [DATA_WIDTH-1:0] Mem_Read_Data
);
  state_t state, next;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [1:0]            size_q, cnt;
  logic                  write_q, uns_q, err_q;
  logic [DATA_WIDTH-1:0] wdata_q, word_q, load_data, merged;
  logic                  accept, last_read;

  assign accept    = Req_Valid & Req_Ready;
  assign last_read = cnt == 2'(READ_LATENCY);

  lsu_lane_align u_load (
    .word_in(word_q), .lane(addr_q[1:0]), .size(size_q), .is_unsigned(uns_q),
    .merge(1'b0), .wdata(wdata_q), .data_out(load_data)
  );

  lsu_lane_align u_merge (
    .word_in(word_q), .lane(addr_q[1:0]), .size(size_q), .is_unsigned(uns_q),
    .merge(1'b1), .wdata(wdata_q), .data_out(merged)
  );

  // state, request registers, read-wait counter and captured memory word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
      cnt     <= '0;
    end else begin
      state <= next;
      if (accept) begin
        addr_q  <= Req_Addr;
        size_q  <= Req_Size;
        write_q <= Req_Write;
        uns_q   <= Req_Unsigned;
        err_q   <= is_misaligned(Req_Size, Req_Addr[1:0]);
        wdata_q <= Req_Wdata;
        cnt     <= '0;
      end else if (state == READ) begin
        cnt <= cnt + 2'd1;
        if (last_read) word_q <= Mem_Read_Data;
      end
    end
  end

  // next-state selection and state-decoded outputs, all zero outside their active state
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (accept) next = is_misaligned(Req_Size, Req_Addr[1:0]) ? RESP :
                                  (Req_Write && Req_Size[1]) ? WRITE : READ;
      READ:    if (last_read) next = write_q ? WRITE : RESP;
      WRITE:   next = RESP;
      default: next = IDLE;
    endcase
    Req_Ready      = rst_n && state == IDLE;
    Mem_Read       = state == READ;
    Mem_Write      = state == WRITE;
    Mem_Address    = (Mem_Read || Mem_Write) ? addr_q[ADDR_WIDTH+1:2] : '0;
    Mem_Write_Data = Mem_Write ? merged : '0;
    Resp_Valid     = state == RESP;
    Resp_Error     = Resp_Valid && err_q;
    Resp_Rdata     = (Resp_Valid && !err_q && !write_q) ? load_data : '0;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the data-memory interface; sits between the CPU execute stage and data_memory. Accepts one load/store request at a time over a valid/ready handshake and drives data_memory's word-addressed Address/Write_Data/Mem_Write/Mem_Read port. Adds byte/halfword support: sub-word stores use read-modify-write, and sub-word loads are sign- or zero-extended. Returns one response per request, including store acknowledges and misalignment errors.

Parameters:
DATA_WIDTH, 32, word width. Fixed at 32 because the byte-lane logic assumes 4 lanes.
ADDR_WIDTH, 8, word-address width of data_memory.
READ_LATENCY, 1, clock edges from Mem_Read/Mem_Address presentation until Mem_Read_Data is valid. Range 0..3.

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
Req_Valid  in  1  request present
Req_Ready  out  1  LSU can accept a request; high only in IDLE
Req_Write  in  1  1 = store, 0 = load
Req_Size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
Req_Unsigned  in  1  load zero-extends when 1, sign-extends when 0
Req_Addr  in  ADDR_WIDTH+2  byte address; [1:0] selects the lane, [ADDR_WIDTH+1:2] is the word address
Req_Wdata  in  DATA_WIDTH  store data, right-aligned
Resp_Valid  out  1  one-cycle response pulse
Resp_Error  out  1  misaligned request; valid with Resp_Valid
Resp_Rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
Mem_Address  out  ADDR_WIDTH  to data_memory Address
Mem_Write_Data  out  DATA_WIDTH  to data_memory Write_Data
Mem_Write  out  1  to data_memory Mem_Write
Mem_Read  out  1  to data_memory Mem_Read
Mem_Read_Data  in  DATA_WIDTH  from data_memory Read_Data

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE immediately, even mid-operation; an in-flight access is aborted with no response.
  - All outputs are 0, including Req_Ready and Mem_Write. Request registers clear.
  - Req_Ready=1 from the first cycle after rst_n deasserts.
- FSM states: IDLE, READ, WRITE, RESP.
- Handshake (edge 0): on Req_Valid & Req_Ready, latch addr, size, write flag, unsigned flag and wdata. Req_Valid without Req_Ready is ignored. Inputs are not sampled outside IDLE.
- Misaligned check:
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - IDLE goes directly to RESP with Resp_Error=1 and no memory access.
  - Resp_Valid is in cycle 1.
- Word store:
  - IDLE -> WRITE.
  - Cycle 1: Mem_Write=1, Mem_Address=word addr, Mem_Write_Data=wdata.
  - RESP in cycle 2; Resp_Valid=1, Resp_Rdata=0.
- Load, or sub-word store (RMW):
  - IDLE -> READ; a counter counts READ_LATENCY+1 cycles.
  - Mem_Read=1 and Mem_Address are held stable for cycles 1..READ_LATENCY+1.
  - Mem_Read_Data is captured at the end of the last READ cycle.
- Load completion: READ -> RESP. Resp_Valid is in cycle READ_LATENCY+2.
  - Byte: lane addr[1:0], little-endian (lane 0 = bits 7:0).
  - Half: lane addr[1], 0 = bits 15:0.
  - Extension is selected by Req_Unsigned.
- Sub-word store completion: READ -> WRITE.
  - Merge the new byte/half into the captured word.
  - Mem_Write=1 in cycle READ_LATENCY+2.
  - RESP in cycle READ_LATENCY+3.
- RESP lasts exactly one cycle, then IDLE. Req_Ready=0 during RESP, so back-to-back requests are spaced by at least one IDLE cycle.
- Mem_Write and Mem_Read are never high together. Both are 0 in IDLE and RESP.
- Mem_Write_Data is 0 when Mem_Write=0.
- Address wrap: the word address is taken modulo 2^ADDR_WIDTH with no overflow flag; the max address is legal.

Decomposition:
- Package lsu_pkg:
  - size encodings SIZE_BYTE/HALF/WORD
  - FSM state enum
  - function is_misaligned(size, addr[1:0])
- Sub-module lsu_lane_align, combinational: load extract/extend and store merge (word_in, lane, size, unsigned, wdata -> word_out/rdata). Instantiated once for load and once for merge.

Test Plan:
- Word store: 0xA5A5A5A5 @ byte addr 0x040, then word load @ 0x040 -> Mem_Write pulses 1 cycle with Mem_Address=0x10; load Resp_Rdata=0xA5A5A5A5, Resp_Valid at cycle 3 (READ_LATENCY=1).
- Byte loads from word 0x80FF7F01 @ 0x044: signed byte addr 0x046 -> 0xFFFFFFFF; unsigned byte 0x047 -> 0x00000080; signed half 0x044 -> 0x00007F01.
- Byte store 0x5A to 0x041 over 0xA5A5A5A5 -> Mem_Read phase, then Mem_Write with 0xA5A55AA5; reload returns 0xA5A55AA5; ack at cycle 4.
- Misaligned word load @ 0x042 and half store @ 0x045 -> Resp_Valid cycle 1, Resp_Error=1, Resp_Rdata=0, Mem_Read/Mem_Write never asserted.
- rst_n pulled low during READ of a load -> outputs 0 immediately, no Resp_Valid; Req_Ready=1 the cycle after release; next word load returns correct data.
- Max address: word store 0x12345678 @ byte addr 0x3FC, then load -> Mem_Address=0xFF, data 0x12345678; Req_Valid held during RESP is not accepted until IDLE.
